rv_mc_sequencer: RTL
====================

RV_MC_SEQUENCER -- requirements
Module: rv_mc_sequencer

Interface
REQ-001 SHALL have parameter: MEM_TIMEOUT, default 15, maximum number of cycles to wait for mem_ack before timing out.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: inst  input  32  current instruction-register contents.
REQ-005 SHALL have port: mem_ack  input  1  memory completion for the current request.
REQ-006 SHALL have ports (outputs, 1 bit each): mem_req (memory request), mem_we (store), addr_sel (0=PC, 1=ALU result), ir_we (instruction-register load), pc_we (PC+4 update), alusrc_b (0=rs2, 1=immediate), wb_sel (0=ALU, 1=memory), RegWEn (register-file write), trap (sticky fault).
REQ-007 SHALL have ports: ALUSel  output  4  ALU operation; state  output  3  current state, for debug.

Function
REQ-008 SHALL have states: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, TRAP=5.
REQ-009 In FETCH, SHALL drive mem_req=1 and addr_sel=0; when mem_ack=1, SHALL pulse ir_we=1 and pc_we=1 in that same cycle, then go to DECODE.
REQ-010 DECODE SHALL last exactly 1 cycle and classify the opcode: 0110011 R-type, 0010011 I-ALU, 0000011 LW, 0100011 SW; any other opcode is illegal.
REQ-011 EXECUTE SHALL last 1 cycle and drive ALUSel.
- R-type and I-ALU go to WRITEBACK; LW and SW go to MEMORY.
- alusrc_b=1 for I-ALU, LW and SW.
- LW and SW use ALUSel=0010 (ADD).
REQ-012 ALUSel encoding SHALL be: ADD 0010, SUB 0110, AND 0000, OR 0001, XOR 0011, SLL 0100, SRL 0101, SLT 0111, SRA 1000, SLTU 1001.
- SUB is selected when funct3=000 and inst[30]=1, for R-type only.
- SRA is selected when funct3=101 and inst[30]=1.
REQ-013 In MEMORY, SHALL drive mem_req=1 and addr_sel=1, with mem_we=1 for SW only; on mem_ack, SW goes to FETCH and LW goes to WRITEBACK.
REQ-014 WRITEBACK SHALL last 1 cycle, with RegWEn=1 unless rd (inst[11:7]) is 0, and wb_sel=1 for LW; then go to FETCH.
REQ-015 Outside the conditions stated above, all 1-bit outputs SHALL be 0 and ALUSel SHALL be 0010.
REQ-016 Minimum instruction latency SHALL be: R/I-ALU 4 cycles, SW 4 cycles, LW 5 cycles, each with a single-cycle ack.
REQ-017 A wait counter SHALL:
- clear on entry to FETCH or MEMORY;
- increment each cycle that mem_req=1 and mem_ack=0;
- saturate at MEM_TIMEOUT.
REQ-018 A mem_ack received outside FETCH or MEMORY SHALL be ignored.
REQ-019 inst SHALL be sampled only in DECODE, EXECUTE and WRITEBACK; the surrounding datapath holds the instruction register stable during those states.

Reset
REQ-020 On rst_n=0, SHALL asynchronously enter FETCH, clear the wait counter and clear trap.
REQ-021 During reset, all outputs SHALL be 0 except ALUSel=0010.
REQ-022 Reset asserted mid-MEMORY SHALL abandon the access, with no RegWEn pulse.
REQ-023 After rst_n deasserts, mem_req SHALL assert in the first cycle.

Configuration
REQ-024 With RV_MC_TRAP_EN defined:
- an illegal opcode in DECODE SHALL go to TRAP;
- a wait counter reaching MEM_TIMEOUT SHALL go to TRAP;
- TRAP SHALL hold trap=1 and all other outputs inactive until reset.
REQ-025 Without RV_MC_TRAP_EN:
- an illegal opcode SHALL execute as a NOP (DECODE to FETCH, no RegWEn);
- the timeout SHALL be disabled and the sequencer waits indefinitely for mem_ack;
- trap SHALL be tied to 0 and TRAP SHALL be unreachable.

Structure
REQ-026 Package rv_mc_pkg SHALL hold the state enum, the opcode constants and the ALUSel constants.
REQ-027 The ALU-op decode (opcode, funct3 and inst[30] to ALUSel) SHALL be a combinational sub-module, rv_alu_decode, instantiated once.

Verification
REQ-028 Bench SHALL cover: inst=0x40B50533 (sub x10,x10,x11) with ack after 1 cycle -> ALUSel=0110 in EXECUTE, RegWEn=1 exactly 4 cycles after the fetch request.
REQ-029 Bench SHALL cover: inst=0x00452503 (lw x10,4(x10)) with 3-cycle ack latency in MEMORY -> addr_sel=1, mem_we=0, then wb_sel=1 and RegWEn=1 for one cycle.
REQ-030 Bench SHALL cover: inst=0x00A5A023 (sw) -> mem_we=1 in MEMORY, RegWEn never asserted, return to FETCH.
REQ-031 Bench SHALL cover: inst=0x00000033 (add x0) -> RegWEn stays 0 in WRITEBACK.
REQ-032 Bench SHALL cover: inst=0xFFFFFFFF -> TRAP with trap=1 when RV_MC_TRAP_EN is defined; otherwise NOP and return to FETCH.
REQ-033 Bench SHALL cover: mem_ack held 0 for 15 cycles in FETCH -> TRAP when RV_MC_TRAP_EN is defined; then rst_n pulse -> state=0, trap=0.

Source files
------------

// File: rtl/rv_mc_pkg.sv
// ----------------------------------------------------------------------------
// rv_mc_pkg
// Shared definitions for the multi-cycle RV32I control sequencer:
//   - state_e : sequencer state encoding (also exported on the debug port)
//   - cls_e   : instruction class latched in DECODE
//   - OPC_*   : major opcode constants for the supported instruction classes
//   - ALU_*   : ALUSel operation encodings
//   - classify(): opcode -> instruction class
// Optional feature macro used by the sequencer: RV_MC_TRAP_EN.
// ----------------------------------------------------------------------------
package rv_mc_pkg;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_TRAP      = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        CLS_R   = 3'd0,
        CLS_I   = 3'd1,
        CLS_LW  = 3'd2,
        CLS_SW  = 3'd3,
        CLS_ILL = 3'd4
    } cls_e;

    localparam logic [6:0] OPC_R  = 7'b0110011;
    localparam logic [6:0] OPC_I  = 7'b0010011;
    localparam logic [6:0] OPC_LW = 7'b0000011;
    localparam logic [6:0] OPC_SW = 7'b0100011;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    function automatic cls_e classify(input logic [6:0] opc);
        cls_e c;
        case (opc)
            OPC_R:   c = CLS_R;
            OPC_I:   c = CLS_I;
            OPC_LW:  c = CLS_LW;
            OPC_SW:  c = CLS_SW;
            default: c = CLS_ILL;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/rv_alu_decode.sv
// ----------------------------------------------------------------------------
// rv_alu_decode
// Purely combinational ALU-operation decode.
// Ports:
//   opcode_i  [6:0] instruction opcode field
//   funct3_i  [2:0] instruction funct3 field
//   inst30_i        instruction bit 30 (funct7[5])
//   alu_sel_o [3:0] ALU operation (ADD for anything that is not R/I-ALU)
// ----------------------------------------------------------------------------
module rv_alu_decode
    import rv_mc_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic       inst30_i,
    output logic [3:0] alu_sel_o
);

    logic is_r;
    logic is_alu;

    assign is_r   = (opcode_i == OPC_R);
    assign is_alu = is_r || (opcode_i == OPC_I);

    always_comb begin
        alu_sel_o = ALU_ADD;
        if (is_alu) begin
            case (funct3_i)
                // For I-ALU, bit 30 is part of the immediate, so only
                // R-type may select SUB.
                3'b000: alu_sel_o = (is_r && inst30_i) ? ALU_SUB : ALU_ADD;
                3'b001: alu_sel_o = ALU_SLL;
                3'b010: alu_sel_o = ALU_SLT;
                3'b011: alu_sel_o = ALU_SLTU;
                3'b100: alu_sel_o = ALU_XOR;
                // Shift-immediates carry funct7 in imm[11:5], so bit 30
                // distinguishes SRA/SRL for both forms.
                3'b101: alu_sel_o = inst30_i ? ALU_SRA : ALU_SRL;
                3'b110: alu_sel_o = ALU_OR;
                3'b111: alu_sel_o = ALU_AND;
            endcase
        end
    end

endmodule

// File: rtl/rv_mc_sequencer.sv
// ----------------------------------------------------------------------------
// rv_mc_sequencer
// Control FSM for a multi-cycle RV32I subset (R-type, I-ALU, LW, SW):
// FETCH -> DECODE -> EXECUTE -> [MEMORY] -> [WRITEBACK] -> FETCH.
//
// Parameter:
//   MEM_TIMEOUT  wait-counter saturation value (cycles without mem_ack), >= 1
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   inst[31:0]   instruction register (read in DECODE/EXECUTE/WRITEBACK)
//   mem_ack      memory completion; honoured only in FETCH and MEMORY
//   mem_req      memory request (FETCH, MEMORY)
//   mem_we       store strobe (MEMORY, SW)
//   addr_sel     address mux: 0=PC, 1=ALU result
//   ir_we, pc_we instruction-register load / PC+4 update on fetch ack
//   alusrc_b     ALU B operand: 0=rs2, 1=immediate (EXECUTE)
//   wb_sel       writeback mux: 0=ALU, 1=memory (WRITEBACK, LW)
//   RegWEn       register-file write (WRITEBACK, rd != 0)
//   trap         sticky fault indicator
//   ALUSel[3:0]  ALU operation; ADD outside EXECUTE
//   state[2:0]   current state, for debug
//
// Handshake: a memory access is one request held high (mem_req=1, with
// stable addr_sel/mem_we) until the cycle in which mem_ack=1 is seen; that
// cycle completes the access and the sequencer leaves the state on the next
// rising edge. mem_ack outside FETCH/MEMORY has no effect.
//
// Optional feature macro: RV_MC_TRAP_EN
//   defined   : illegal opcode or a memory wait reaching MEM_TIMEOUT enters
//               TRAP, which holds trap=1 until reset.
//   undefined : illegal opcodes retire as NOPs, memory waits are unbounded,
//               trap is constant 0.
//
// Outputs are decoded from the registered state (and mem_ack for the fetch
// strobes, which must fire in the ack cycle); all of them are forced to
// their idle values while rst_n is low.
// ----------------------------------------------------------------------------
module rv_mc_sequencer
    import rv_mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic        alusrc_b,
    output logic        wb_sel,
    output logic        RegWEn,
    output logic        trap,
    output logic [3:0]  ALUSel,
    output logic [2:0]  state
);

    localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] TIMEOUT_MAX = CW'(MEM_TIMEOUT);

`ifdef RV_MC_TRAP_EN
    localparam state_e ILLEGAL_NEXT = S_TRAP;
`else
    localparam state_e ILLEGAL_NEXT = S_FETCH;
`endif

    state_e          state_q, state_d;
    cls_e            cls_q, cls_d;
    logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
    logic            mem_phase;
    logic            timeout_hit;
    logic [3:0]      alu_sel_exec;

    // Fields of inst that this block never looks at (register indices and
    // immediates are consumed by the datapath).
    logic unused_inst_bits;
    assign unused_inst_bits = ^{inst[31], inst[29:15]};

    rv_alu_decode u_alu_decode (
        .opcode_i  (inst[6:0]),
        .funct3_i  (inst[14:12]),
        .inst30_i  (inst[30]),
        .alu_sel_o (alu_sel_exec)
    );

    assign mem_phase = (state_q == S_FETCH) || (state_q == S_MEMORY);

    // The wait counter reaches MEM_TIMEOUT on the edge that ends the
    // MEM_TIMEOUT-th unacknowledged cycle; leave for TRAP on that same edge.
`ifdef RV_MC_TRAP_EN
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(MEM_TIMEOUT - 1);
    assign timeout_hit = mem_phase && !mem_ack && (wait_cnt_q >= TIMEOUT_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cls_d      = cls_q;
        wait_cnt_d = wait_cnt_q;

        case (state_q)
            S_FETCH: begin
                if (mem_ack) begin
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                end
            end
            S_DECODE: begin
                cls_d = classify(inst[6:0]);
                if (cls_d == CLS_ILL) begin
                    state_d = ILLEGAL_NEXT;
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                if (cls_q == CLS_LW || cls_q == CLS_SW) begin
                    state_d = S_MEMORY;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                // inst is not guaranteed stable here, so LW/SW comes from
                // the class latched in DECODE.
                if (mem_ack) begin
                    state_d = (cls_q == CLS_SW) ? S_FETCH : S_WRITEBACK;
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                end
            end
            S_WRITEBACK: begin
                state_d = S_FETCH;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Fresh count for every new access; otherwise count unacknowledged
        // request cycles, saturating.
        if ((state_d == S_FETCH || state_d == S_MEMORY) && (state_d != state_q)) begin
            wait_cnt_d = '0;
        end else if (mem_phase && !mem_ack && (wait_cnt_q != TIMEOUT_MAX)) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            cls_q      <= CLS_ILL;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cls_q      <= cls_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        addr_sel = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        alusrc_b = 1'b0;
        wb_sel   = 1'b0;
        RegWEn   = 1'b0;
        trap     = 1'b0;
        ALUSel   = ALU_ADD;

        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    mem_req = 1'b1;
                    ir_we   = mem_ack;
                    pc_we   = mem_ack;
                end
                S_EXECUTE: begin
                    ALUSel   = alu_sel_exec;
                    alusrc_b = (cls_q != CLS_R);
                end
                S_MEMORY: begin
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                    mem_we   = (cls_q == CLS_SW);
                end
                S_WRITEBACK: begin
                    RegWEn = (inst[11:7] != 5'd0);
                    wb_sel = (cls_q == CLS_LW);
                end
                S_TRAP: begin
`ifdef RV_MC_TRAP_EN
                    trap = 1'b1;
`endif
                end
                default: begin
                end
            endcase
        end
    end

    assign state = state_q;

endmodule
